// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, multiplier FSM states and Booth recoding.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic [1:0] BOOTH_NOP = 2'd0;
  localparam logic [1:0] BOOTH_ADD = 2'd1;
  localparam logic [1:0] BOOTH_SUB = 2'd2;

  // Radix-2 recoding of the current multiplier bit and the guard bit below it.
  function automatic logic [1:0] booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_multiplier_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then an
// arithmetic right shift of {acc, q, q_m1}.
module booth_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic signed [WIDTH:0] sum;
  logic [1:0]            op;

  always_comb begin
    op  = booth_decode(q[0], q_m1);
    sum = $signed(acc);
    case (op)
      BOOTH_ADD: sum = $signed(acc) + $signed(m);
      BOOTH_SUB: sum = $signed(acc) - $signed(m);
      default:   sum = $signed(acc);
    endcase
  end

  // The bit shifted out of sum feeds the top of q; sum's sign bit is replicated.
  assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier, one multiplier bit per clock,
// with a start/busy/done handshake and registered HI/LO product halves.
module booth_multiplier
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mul_state_t            state;
  logic signed [WIDTH:0] m;
  logic signed [WIDTH:0] acc;
  logic [WIDTH:0]        acc_next;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      q_next;
  logic                  q_m1;
  logic                  q_m1_next;
  logic [CNT_W-1:0]      cnt;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc),
    .q        (q),
    .q_m1     (q_m1),
    .m        (m),
    .acc_next (acc_next),
    .q_next   (q_next),
    .q_m1_next(q_m1_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
      m          <= '0;
      acc        <= '0;
      q          <= '0;
      q_m1       <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        // DONE accepts a new start just like IDLE, giving WIDTH+1 cycle throughput.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= $signed({a[WIDTH-1], a});
            acc   <= '0;
            q     <= b;
            q_m1  <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc  <= $signed(acc_next);
          q    <= q_next;
          q_m1 <= q_m1_next;
          cnt  <= cnt - CNT_W'(1);
          // Last iteration: capture the shifted result directly from the step.
          if (cnt == CNT_W'(1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            product_hi <= acc_next[WIDTH-1:0];
            product_lo <= q_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
